l2_cache_ctrl: RTL and testbench
================================

Name: l2_cache_ctrl

Overview:
- Second-level, direct-mapped, write-through, no-write-allocate cache controller.
- Sits directly downstream of the L1 cache and consumes the L1 miss address and write-through traffic.
- Returns whole 4-word lines to L1 on read; on an L2 miss it refills the line from main memory over a valid/ready request channel and a 4-beat response stream.
- One outstanding L1 request at a time.

Parameters:
- L2_LINES, 1024, number of cache lines
- L2_INDEX_BITS, 10, index width, addr[13:4]
- L2_TAG_BITS, 18, tag width, addr[31:14]
- L2_OFFSET_BITS, 4, byte offset within a 16-byte line; word select is addr[3:2], addr[1:0] ignored
- L2_WORDS, 4, 32-bit words per line

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- l1_req_valid  in  1  L1 request present
- l1_req_ready  out  1  controller can accept request
- l1_req_addr  in  32  byte address from L1 miss/write
- l1_req_we  in  1  1 = word write-through, 0 = line read
- l1_req_wdata  in  32  write data
- l1_resp_valid  out  1  one-cycle response/ack pulse
- l1_resp_data  out  128  line, word k at [32k+31:32k]
- l1_resp_hit  out  1  request hit in L2
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  line-aligned (read) or word address (write)
- mem_req_we  out  1  memory write
- mem_req_wdata  out  32  memory write data
- mem_resp_valid  in  1  refill beat valid
- mem_resp_data  in  32  refill beat, word order 0..3

Behaviour:
- Reset (async):
  - state=IDLE; all valid bits=0.
  - Outputs: l1_req_ready=0 while rst is high; l1_resp_valid=0, l1_resp_data=0, l1_resp_hit=0, mem_req_valid=0, mem_req_addr=0, mem_req_we=0, mem_req_wdata=0.
  - Tag and data arrays are not cleared.
- IDLE:
  - l1_req_ready=1.
  - On l1_req_valid&ready, latch addr/we/wdata, go to LOOKUP.
- LOOKUP (1 cycle), with hit = valid[idx] && tag[idx]==addr[31:14]:
  - Read hit: go to RESP with the stored line.
  - Read miss: go to MEM_REQ.
  - Write hit: update word addr[3:2] of the line, then go to WR_MEM.
  - Write miss: no array change, go to WR_MEM.
- MEM_REQ:
  - Drive mem_req_valid=1, we=0, addr={addr[31:4],4'b0}.
  - Hold until mem_req_ready; then beat=0 and go to MEM_FILL.
- MEM_FILL:
  - Each mem_resp_valid writes mem_resp_data into line word[beat]; beat increments (2-bit).
  - On beat 3: write tag, set valid, go to RESP.
  - Gaps between beats are allowed.
- WR_MEM:
  - Drive mem_req_valid=1, we=1, addr={addr[31:2],2'b0}, wdata.
  - On mem_req_ready, go to RESP.
- RESP:
  - l1_resp_valid=1 for exactly one cycle, then go to IDLE.
  - l1_resp_data = line (read) or updated line on write hit, 0 on write miss.
  - l1_resp_hit reflects the LOOKUP result.
  - L1 never back-pressures responses.
- Latency:
  - Read hit: response valid in the 2nd cycle after the accept edge.
  - Read miss: 2 + memory handshake + 4 beats.
- mem_req_* are held stable while mem_req_valid=1 && !mem_req_ready.
- mem_resp_valid outside MEM_FILL is ignored.
- l1_req_ready=0 in every state except IDLE; a request arriving while busy is held by L1.
- Reset mid-MEM_FILL: the partial line is not validated; stray memory beats after reset are ignored.
- A refill overwrites the line unconditionally; write-through means there is never a dirty eviction.

Optional Feature:
- Macro: L2_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
  - The relevant counter increments once per LOOKUP, reads and writes alike.
  - Counters saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset, then read 0x00001234 -> mem_req addr 0x00001230 we=0; feed beats 0xA0,0xA1,0xA2,0xA3 -> l1_resp_data={A3,A2,A1,A0}, hit=0, single-cycle l1_resp_valid.
2. Read 0x00001238 next -> hit=1, same line returned 2 cycles after accept, no mem_req_valid.
3. Write 0x00001238 data 0xDEADBEEF -> hit=1, mem write addr 0x00001238 data 0xDEADBEEF; then read 0x00001230 returns word2=0xDEADBEEF.
4. Read 0x00041230 (same index 0x123, tag 0x10) -> miss, refill with 0xB0..0xB3; then read 0x00001230 -> miss again.
5. Start miss on 0x00002000, hold mem_req_ready=0 for 5 cycles -> request stable; assert rst after 2 refill beats -> state IDLE, outputs 0; repeat read 0x00002000 -> miss.
6. Write miss to 0x00005000 data 0x11 -> mem write issued, hit=0, resp_data=0; subsequent read 0x00005000 -> miss. With L2_STATS_EN, check final hit_count/miss_count match the sequence.

Source files
------------

// File: rtl/l2_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L2 cache controller with 4-word line refill.
// Optional hit/miss counters are built when L2_STATS_EN is defined.
module l2_cache_ctrl #(
  parameter int unsigned L2_LINES       = 1024,
  parameter int unsigned L2_INDEX_BITS  = 10,
  parameter int unsigned L2_TAG_BITS    = 18,
  parameter int unsigned L2_OFFSET_BITS = 4,
  parameter int unsigned L2_WORDS       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         l1_req_valid,
  output logic         l1_req_ready,
  input  logic [31:0]  l1_req_addr,
  input  logic         l1_req_we,
  input  logic [31:0]  l1_req_wdata,
  output logic         l1_resp_valid,
  output logic [127:0] l1_resp_data,
  output logic         l1_resp_hit,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [31:0]  mem_req_addr,
  output logic         mem_req_we,
  output logic [31:0]  mem_req_wdata,
  input  logic         mem_resp_valid,
  input  logic [31:0]  mem_resp_data
`ifdef L2_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_FILL, WR_MEM, RESP} state_t;
  state_t state, state_nx;

  logic [31:0]  addr_q;
  logic [31:0]  wdata_q;
  logic         we_q;
  logic         hit_q;
  logic [1:0]   beat;
  logic [127:0] line_q;

  logic [L2_LINES-1:0]    valid_arr;
  logic [L2_TAG_BITS-1:0] tag_arr  [L2_LINES];
  logic [31:0]            data_arr [L2_LINES][L2_WORDS];

  logic [L2_INDEX_BITS-1:0] idx;
  logic [L2_TAG_BITS-1:0]   tag_in;
  logic [1:0]               wsel;
  logic                     lookup_hit;
  logic [127:0]             stored_line;
  logic [127:0]             merged_line;
  logic                     unused_addr_bits;

  assign idx              = addr_q[L2_OFFSET_BITS +: L2_INDEX_BITS];
  assign tag_in           = addr_q[31 -: L2_TAG_BITS];
  assign wsel             = addr_q[3:2];
  assign lookup_hit       = valid_arr[idx] && (tag_arr[idx] == tag_in);
  assign unused_addr_bits = ^addr_q[1:0];

  always_comb begin
    stored_line = '0;
    for (int unsigned k = 0; k < L2_WORDS; k++)
      stored_line[32*k +: 32] = data_arr[idx][k];
    merged_line = stored_line;
    merged_line[{wsel, 5'b0} +: 32] = wdata_q;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (l1_req_valid) state_nx = LOOKUP;
      LOOKUP:   state_nx = we_q ? WR_MEM : (lookup_hit ? RESP : MEM_REQ);
      MEM_REQ:  if (mem_req_ready) state_nx = MEM_FILL;
      MEM_FILL: if (mem_resp_valid && beat == 2'd3) state_nx = RESP;
      WR_MEM:   if (mem_req_ready) state_nx = RESP;
      RESP:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    l1_req_ready  = (state == IDLE) && !rst;
    l1_resp_valid = 1'b0;
    l1_resp_data  = '0;
    l1_resp_hit   = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_we    = 1'b0;
    mem_req_wdata = '0;
    if (state == RESP) begin
      l1_resp_valid = 1'b1;
      l1_resp_data  = line_q;
      l1_resp_hit   = hit_q;
    end
    if (state == MEM_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = {addr_q[31:4], 4'b0};
    end
    if (state == WR_MEM) begin
      mem_req_valid = 1'b1;
      mem_req_we    = 1'b1;
      mem_req_addr  = {addr_q[31:2], 2'b0};
      mem_req_wdata = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      hit_q     <= 1'b0;
      beat      <= '0;
      line_q    <= '0;
      valid_arr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && l1_req_valid) begin
        addr_q  <= l1_req_addr;
        we_q    <= l1_req_we;
        wdata_q <= l1_req_wdata;
      end
      if (state == LOOKUP) begin
        hit_q  <= lookup_hit;
        line_q <= we_q ? (lookup_hit ? merged_line : '0) : stored_line;
      end
      if (state == MEM_REQ && mem_req_ready) beat <= '0;
      if (state == MEM_FILL && mem_resp_valid) begin
        line_q[{beat, 5'b0} +: 32] <= mem_resp_data;
        beat <= beat + 2'd1;
        if (beat == 2'd3) valid_arr[idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage is deliberately unreset; the valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && we_q && lookup_hit) data_arr[idx][wsel] <= wdata_q;
    if (state == MEM_FILL && mem_resp_valid) begin
      data_arr[idx][beat] <= mem_resp_data;
      if (beat == 2'd3) tag_arr[idx] <= tag_in;
    end
  end

`ifdef L2_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (lookup_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Directed bench for l2_cache_ctrl: a response scoreboard plus a small memory responder.
module tb_l2_cache_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         l1_req_valid = 1'b0;
  logic         l1_req_ready;
  logic [31:0]  l1_req_addr = '0;
  logic         l1_req_we = 1'b0;
  logic [31:0]  l1_req_wdata = '0;
  logic         l1_resp_valid;
  logic [127:0] l1_resp_data;
  logic         l1_resp_hit;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic         mem_req_we;
  logic [31:0]  mem_req_wdata;
  logic         mem_resp_valid = 1'b0;
  logic [31:0]  mem_resp_data = '0;
`ifdef L2_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  l2_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .l1_req_valid(l1_req_valid), .l1_req_ready(l1_req_ready),
    .l1_req_addr(l1_req_addr), .l1_req_we(l1_req_we), .l1_req_wdata(l1_req_wdata),
    .l1_resp_valid(l1_resp_valid), .l1_resp_data(l1_resp_data), .l1_resp_hit(l1_resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef L2_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] data; logic hit; } resp_t;
  resp_t exp_q[$];
  resp_t e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int resp_cyc = 0;
  int resp_cnt = 0;
  int resp_base = 0;
  int mem_cycles = 0;

  localparam logic [127:0] LINE_A  = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] LINE_AW = 128'h000000A3_DEADBEEF_000000A1_000000A0;
  localparam logic [127:0] LINE_B  = 128'h000000B3_000000B2_000000B1_000000B0;
  localparam logic [127:0] LINE_D  = 128'h000000D3_000000D2_000000D1_000000D0;
  localparam logic [127:0] LINE_C  = 128'h000000C3_000000C2_000000C1_000000C0;
  localparam logic [127:0] LINE_P  = 128'h000000F3_000000F2_000000F1_000000F0;
  localparam logic [127:0] LINE_E  = 128'h000000E3_000000E2_000000E1_000000E0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_req_valid === 1'b1) mem_cycles++;
    if (l1_resp_valid === 1'b1) begin
      resp_cnt++;
      resp_cyc = cyc;
      if (exp_q.size() == 0) chk("sb_unexpected_resp", 128'(resp_cnt), 128'(resp_base));
      else begin
        e = exp_q.pop_front();
        chk("sb_data", l1_resp_data, e.data);
        chk("sb_hit", 128'(l1_resp_hit), 128'(e.hit));
      end
    end
  end

  task automatic expect_resp(input logic [127:0] d, input logic h);
    resp_t r;
    r.data = d;
    r.hit  = h;
    exp_q.push_back(r);
  endtask

  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd);
    @(negedge clk);
    chk("req_ready_idle", 128'(l1_req_ready), 128'(1'b1));
    resp_base    = resp_cnt;
    l1_req_valid = 1'b1;
    l1_req_addr  = a;
    l1_req_we    = we;
    l1_req_wdata = wd;
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    l1_req_valid = 1'b0;
    @(negedge clk);
    chk("req_ready_busy", 128'(l1_req_ready), 128'(1'b0));
  endtask

  task automatic wait_resp();
    int n = 0;
    while (resp_cnt == resp_base && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("resp_arrived", 128'(resp_cnt - resp_base), 128'd1);
    @(negedge clk);
    chk("resp_pulse", 128'(l1_resp_valid), 128'(1'b0));
  endtask

  task automatic wait_mem(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 40 && !ok) begin
      @(negedge clk);
      if (mem_req_valid === 1'b1) ok = 1'b1;
      n++;
    end
    chk("mem_req_seen", 128'(ok), 128'(1'b1));
  endtask

  task automatic serve_read(input logic [31:0] exp_addr, input logic [127:0] line,
                            input int stall, input int nbeats, input int gap);
    bit ok;
    wait_mem(ok);
    if (ok) begin
      chk("rd_addr", 128'(mem_req_addr), 128'(exp_addr));
      chk("rd_we", 128'(mem_req_we), 128'(1'b0));
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("rd_hold_valid", 128'(mem_req_valid), 128'(1'b1));
        chk("rd_hold_addr", 128'(mem_req_addr), 128'(exp_addr));
      end
      mem_req_ready = 1'b1;
      @(posedge clk);
      #1;
      mem_req_ready = 1'b0;
      for (int k = 0; k < nbeats; k++) begin
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = line[32*k +: 32];
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        if (k == 1) repeat (gap) @(posedge clk);
      end
    end
  endtask

  task automatic serve_write(input logic [31:0] exp_addr, input logic [31:0] exp_data);
    bit ok;
    wait_mem(ok);
    if (ok) begin
      chk("wr_we", 128'(mem_req_we), 128'(1'b1));
      chk("wr_addr", 128'(mem_req_addr), 128'(exp_addr));
      chk("wr_data", 128'(mem_req_wdata), 128'(exp_data));
      @(negedge clk);
      chk("wr_hold_data", 128'(mem_req_wdata), 128'(exp_data));
      mem_req_ready = 1'b1;
      @(posedge clk);
      #1;
      mem_req_ready = 1'b0;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", 128'(l1_req_ready), 128'(1'b0));
    chk("rst_resp_valid", 128'(l1_resp_valid), 128'(1'b0));
    chk("rst_resp_data", l1_resp_data, 128'd0);
    chk("rst_resp_hit", 128'(l1_resp_hit), 128'(1'b0));
    chk("rst_mem_valid", 128'(mem_req_valid), 128'(1'b0));
    chk("rst_mem_addr", 128'(mem_req_addr), 128'd0);
    chk("rst_mem_we", 128'(mem_req_we), 128'(1'b0));
    chk("rst_mem_wdata", 128'(mem_req_wdata), 128'd0);
`ifdef L2_STATS_EN
    chk("rst_hit_count", 128'(hit_count), 128'd0);
    chk("rst_miss_count", 128'(miss_count), 128'd0);
`endif
  endtask

  initial begin
    int mem_before;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: cold read miss with refill
    expect_resp(LINE_A, 1'b0);
    issue(32'h0000_1234, 1'b0, '0);
    serve_read(32'h0000_1230, LINE_A, 0, 4, 0);
    wait_resp();

    // 2: read hit, latency and no memory traffic
    mem_before = mem_cycles;
    expect_resp(LINE_A, 1'b1);
    issue(32'h0000_1238, 1'b0, '0);
    wait_resp();
    chk("hit_latency", 128'(resp_cyc - acc_cyc), 128'd1);
    chk("hit_no_mem", 128'(mem_cycles), 128'(mem_before));

    // 3: write hit updates word 2, then read it back
    expect_resp(LINE_AW, 1'b1);
    issue(32'h0000_1238, 1'b1, 32'hDEAD_BEEF);
    serve_write(32'h0000_1238, 32'hDEAD_BEEF);
    wait_resp();
    expect_resp(LINE_AW, 1'b1);
    issue(32'h0000_1230, 1'b0, '0);
    wait_resp();

    // 4: conflicting tag evicts, original line then misses
    expect_resp(LINE_B, 1'b0);
    issue(32'h0004_1230, 1'b0, '0);
    serve_read(32'h0004_1230, LINE_B, 0, 4, 2);
    wait_resp();
    expect_resp(LINE_D, 1'b0);
    issue(32'h0000_1230, 1'b0, '0);
    serve_read(32'h0000_1230, LINE_D, 1, 4, 0);
    wait_resp();
`ifdef L2_STATS_EN
    chk("mid_hit_count", 128'(hit_count), 128'd3);
    chk("mid_miss_count", 128'(miss_count), 128'd3);
`endif

    // 5: stalled request, then reset in the middle of the refill
    issue(32'h0000_2000, 1'b0, '0);
    serve_read(32'h0000_2000, LINE_P, 5, 2, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_00FF;
    repeat (2) @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("stray_ready", 128'(l1_req_ready), 128'(1'b1));
    chk("stray_mem_valid", 128'(mem_req_valid), 128'(1'b0));
    expect_resp(LINE_C, 1'b0);
    issue(32'h0000_2000, 1'b0, '0);
    serve_read(32'h0000_2000, LINE_C, 0, 4, 0);
    wait_resp();

    // 6: write miss is not allocated
    expect_resp(128'd0, 1'b0);
    issue(32'h0000_5000, 1'b1, 32'h0000_0011);
    serve_write(32'h0000_5000, 32'h0000_0011);
    wait_resp();
    expect_resp(LINE_E, 1'b0);
    issue(32'h0000_5000, 1'b0, '0);
    serve_read(32'h0000_5000, LINE_E, 0, 4, 0);
    wait_resp();
    expect_resp(LINE_E, 1'b1);
    issue(32'h0000_5004, 1'b0, '0);
    wait_resp();
`ifdef L2_STATS_EN
    chk("end_hit_count", 128'(hit_count), 128'd1);
    chk("end_miss_count", 128'(miss_count), 128'd3);
`endif

    chk("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
